// File: rtl/auction_pkg.sv
// Shared definitions for the auction award return path: FSM encoding,
// bidder-count helper and default note field widths.
package auction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NOTE_ID_W    = 2;
  localparam int unsigned NOTE_PRICE_W = 2;

  function automatic int unsigned bidder_count(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/auction_award_dispatch_if.sv
// Result intake, notice stream and award/status bundle of the award dispatcher.
interface auction_award_dispatch_if
  import auction_pkg::*;
#(
  parameter int unsigned N = NOTE_ID_W,
  parameter int unsigned W = NOTE_PRICE_W
);
  logic                       res_valid;
  logic                       res_ready;
  logic [N-1:0]               winner;
  logic [W-1:0]               winning_bid;
  logic                       cancel;
  logic                       note_valid;
  logic                       note_ready;
  logic [N-1:0]               note_id;
  logic                       note_win;
  logic [W-1:0]               note_price;
  logic [bidder_count(N)-1:0] award;
  logic                       done;
  logic                       busy;

  modport slave (
    input  res_valid, winner, winning_bid, cancel, note_ready,
    output res_ready, note_valid, note_id, note_win, note_price, award, done, busy
  );

  modport master (
    output res_valid, winner, winning_bid, cancel, note_ready,
    input  res_ready, note_valid, note_id, note_win, note_price, award, done, busy
  );
endinterface

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder, N select bits to 2**N outputs.
module onehot_dec
  import auction_pkg::*;
#(
  parameter int unsigned N = NOTE_ID_W
) (
  input  logic [N-1:0]               sel,
  output logic [bidder_count(N)-1:0] dec
);
  always_comb begin
    dec      = '0;
    dec[sel] = 1'b1;
  end
endmodule

// File: rtl/auction_award_dispatch.sv
// Delivers a resolved auction result to every bidder as a notice stream,
// then latches the one-hot award vector and pulses done.
module auction_award_dispatch
  import auction_pkg::*;
#(
  parameter int unsigned N = NOTE_ID_W,
  parameter int unsigned W = NOTE_PRICE_W
) (
  input logic                      clk,
  input logic                      rst_n,
  auction_award_dispatch_if.slave  bus
);
  localparam int unsigned NB   = bidder_count(N);
  localparam logic [N-1:0] LAST = '1;

  state_t          state, state_nx;
  logic [N-1:0]    idx;
  logic [N-1:0]    winner_q;
  logic [W-1:0]    bid_q;
  logic [NB-1:0]   award_q;
  logic [NB-1:0]   dec;

  onehot_dec #(.N(N)) u_dec (
    .sel (winner_q),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      winner_q <= '0;
      bid_q    <= '0;
      award_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.res_valid) begin
          winner_q <= bus.winner;
          bid_q    <= bus.winning_bid;
          idx      <= '0;
          award_q  <= '0;
        end
        // idx holds at LAST so the counter never wraps inside a dispatch
        SEND: if (!bus.cancel && bus.note_ready && idx != LAST) idx <= idx + N'(1);
        DONE: award_q <= dec;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx       = state;
    bus.res_ready  = 1'b0;
    bus.note_valid = 1'b0;
    bus.note_id    = '0;
    bus.note_win   = 1'b0;
    bus.note_price = '0;
    bus.done       = 1'b0;
    bus.busy       = (state != IDLE);
    bus.award      = award_q;
    case (state)
      IDLE: begin
        bus.res_ready = 1'b1;
        if (bus.res_valid) state_nx = SEND;
      end
      SEND: begin
        bus.note_valid = 1'b1;
        bus.note_id    = idx;
        bus.note_win   = (idx == winner_q);
        bus.note_price = bus.note_win ? bid_q : '0;
        if (bus.cancel)                         state_nx = IDLE;
        else if (bus.note_ready && idx == LAST) state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: doc/auction_award_dispatch.md
Name: auction_award_dispatch

Overview:
- Return path of the sealed-bid auction datapath: takes the resolved result (winner index, winning bid) and delivers it back to the 2**N bidders.
- Accepts one result via a valid/ready handshake.
- Streams one notice per bidder, index 0 upward, over a second valid/ready channel; the winner's notice carries the price.
- After the last notice, latches a one-hot award vector and pulses done.

Parameters:
- N, 2, log2 of bidder count; bidders = 2**N.
- W, 2, bid/price width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- res_valid  input  1  result available.
- res_ready  output  1  block can accept a result.
- winner  input  N  winning bidder index; sampled on the result handshake.
- winning_bid  input  W  winning price; sampled on the result handshake.
- cancel  input  1  synchronous abort of the in-flight dispatch.
- note_valid  output  1  notice on note_* is valid.
- note_ready  input  1  downstream accepts the notice.
- note_id  output  N  bidder index the notice is addressed to.
- note_win  output  1  1 if note_id is the winner.
- note_price  output  W  winning_bid if note_win, else 0.
- award  output  2**N  one-hot award vector, held between dispatches.
- done  output  1  one-cycle pulse when a dispatch completes.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert into state): state=IDLE, idx=0, winner_q=0, bid_q=0, award=0, done=0, note_valid=0, note_id=0, note_win=0, note_price=0, busy=0. Applies immediately mid-dispatch; no notice or done follows.
- States: IDLE, SEND, DONE.
- IDLE:
  - res_ready=1.
  - On res_valid&res_ready at edge k: capture winner->winner_q and winning_bid->bid_q, clear idx to 0, clear award to 0, move to SEND. note_valid first high in cycle k+1.
- SEND:
  - res_ready=0; note_valid=1; note_id=idx; note_win=(idx==winner_q); note_price=note_win?bid_q:0.
  - note_* stay stable while note_valid&!note_ready.
  - On note_valid&note_ready: if idx==2**N-1, go to DONE; else idx+1.
  - idx is an N-bit counter that never wraps inside a dispatch.
- DONE (one cycle):
  - done=1.
  - award register loads the one-hot decode of winner_q and becomes visible from the next cycle.
  - Next state IDLE.
- cancel:
  - Honoured in SEND only; next state IDLE with no done and award left at 0.
  - Takes priority over a same-cycle note handshake; that notice is void.
  - Ignored in IDLE and DONE.
- Throughput: with note_ready tied high, a dispatch occupies 2**N SEND cycles + 1 DONE cycle. res_ready returns high 2**N+2 cycles after the capture edge.
- busy = (state != IDLE).
- award is held until the next result capture; it is never multi-hot.
- winner and winning_bid are ignored outside the capture edge.

Decomposition:
- Shared package auction_pkg holds:
  - state encoding constants IDLE/SEND/DONE;
  - a function or localparam for bidder count 2**N;
  - note field widths, reused by the bid-side blocks.
- One sub-module: onehot_dec #(N), combinational N -> 2**N decoder feeding the award register.
- FSM, idx counter and capture registers stay in the top.

Test Plan:
- N=2, W=4, winner=2, winning_bid=9, note_ready=1 -> notes (id,win,price) = (0,0,0), (1,0,0), (2,1,9), (3,0,0) in cycles k+1..k+4; done in k+5; award=4'b0100 from k+6; res_ready high k+6.
- Same result with note_ready low for 3 cycles during id=1 -> note_* held stable; id=2 notice follows only after the handshake; done delayed by 3 cycles.
- cancel asserted together with note_ready on id=1 -> IDLE next cycle; no further notices; done never pulses; award=0; res_ready=1.
- rst_n pulled low while id=2 is pending -> all outputs 0 immediately; after release, a new result winner=0, bid=15 dispatches from id=0 normally.
- Back-to-back: res_valid held high with winner=3 then winner=1 -> second result accepted only once back in IDLE; award goes 1000 -> 0000 at the second capture -> 0010 after its DONE.
- winner=3, winning_bid=0 -> id=3 notice has note_win=1 with price 0; award=4'b1000.
